// File: rtl/sysw_sink.sv
// Receives system writes (sysw/syswa/syswl), queues matching {addr, data} pairs in a FIFO
// and drains them over valid/ready; tracks writes lost to overflow.
module sysw_sink #(
    parameter int unsigned DEPTH      = 8,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFFFF00,
    parameter logic [31:0] ADDR_MATCH = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sysw,
    input  logic [31:0]              syswa,
    input  logic [31:0]              syswl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [15:0]              drop_cnt,
    input  logic                     clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [AW-1:0] wr_next;
    logic [CW-1:0] count_next;
    logic          accepted;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;

    // Next-state datapath: push/pop/drop decode and the head entry after this edge
    always_comb begin
        accepted   = sysw && ((syswa & ADDR_MASK) == ADDR_MATCH);
        full       = (count == CW'(DEPTH));
        pop        = out_valid && out_ready;
        push       = accepted && (!full || pop);
        drop       = accepted && full && !pop;
        rd_next    = pop  ? rd_ptr + AW'(1) : rd_ptr;
        wr_next    = push ? wr_ptr + AW'(1) : wr_ptr;
        count_next = count + CW'(push) - CW'(pop);
        // New head is the entry being written now when it lands in the head slot
        if (push && (rd_next == wr_ptr)) begin
            head_addr = syswa;
            head_data = syswl;
        end else begin
            head_addr = mem_addr[rd_next];
            head_data = mem_data[rd_next];
        end
    end

    // FIFO storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= syswa;
            mem_data[wr_ptr] <= syswl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            rd_ptr    <= rd_next;
            wr_ptr    <= wr_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (count_next != '0) begin
                out_addr <= head_addr;
                out_data <= head_data;
            end
            // A drop coinciding with clr_ovf restarts the tally at one
            if (drop) begin
                ovf      <= 1'b1;
                drop_cnt <= clr_ovf ? 16'd1 :
                            (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
            end else if (clr_ovf) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sysw_sink.sv
// Directed bench for sysw_sink: vector table plus hand sequences for full, wrap and reset cases.
module tb_sysw_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        sysw;
    logic [31:0] syswa;
    logic [31:0] syswl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        ovf;
    logic [15:0] drop_cnt;
    logic        clr_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sysw_sink dut (
        .clk(clk), .rst(rst), .sysw(sysw), .syswa(syswa), .syswl(syswl),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .count(count), .ovf(ovf), .drop_cnt(drop_cnt),
        .clr_ovf(clr_ovf)
    );

    typedef struct {
        logic        rst;
        logic        sysw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ready;
        logic        clr;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_count;
        logic        e_ovf;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, input logic c);
        rst = r; sysw = s; syswa = a; syswl = d; out_ready = rdy; clr_ovf = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 32'(i), 32'(i), 1'b0, 1'b0);
            tick();
        end
        idle();
    endtask

    initial begin
        //          rst  sysw addr          data          rdy  clr  valid addr          data          cnt  ovf drop
        vecs[0] = '{1'b1, 1'b0, 32'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'd0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 1'b1, 32'h10,      32'hDEADBEAF, 1'b0, 1'b0, 1'b1, 32'h10,       32'hDEADBEAF, 4'd1, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 1'b1, 32'h100,     32'h1111,     1'b0, 1'b0, 1'b1, 32'h10,       32'hDEADBEAF, 4'd1, 1'b0, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,       32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'hDEADBEAF, 4'd1, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 1'b1, 32'h20,      32'hCAFE0001, 1'b1, 1'b0, 1'b1, 32'h20,       32'hCAFE0001, 4'd1, 1'b0, 16'd0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 1'b0, 32'h20,       32'hCAFE0001, 4'd0, 1'b0, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 32'h0,       32'h0,        1'b1, 1'b0, 1'b0, 32'h20,       32'hCAFE0001, 4'd0, 1'b0, 16'd0};
        vecs[7] = '{1'b0, 1'b1, 32'hFF,      32'h12345678, 1'b0, 1'b0, 1'b1, 32'hFF,       32'h12345678, 4'd1, 1'b0, 16'd0};
        vecs[8] = '{1'b0, 1'b1, 32'h1FF,     32'h9999,     1'b1, 1'b0, 1'b0, 32'hFF,       32'h12345678, 4'd0, 1'b0, 16'd0};

        idle();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst, vecs[i].sysw, vecs[i].addr, vecs[i].data, vecs[i].ready, vecs[i].clr);
            tick();
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d addr", i),  out_addr,        vecs[i].e_addr);
            chk($sformatf("v%0d data", i),  out_data,        vecs[i].e_data);
            chk($sformatf("v%0d count", i), 32'(count),      32'(vecs[i].e_count));
            chk($sformatf("v%0d ovf", i),   32'(ovf),        32'(vecs[i].e_ovf));
            chk($sformatf("v%0d drop", i),  32'(drop_cnt),   32'(vecs[i].e_drop));
        end

        // Fill, overflow by one, ignore a mismatched write while full, then drain in order
        do_reset();
        fill8();
        chk("fill count", 32'(count), 32'd8);
        chk("fill ovf", 32'(ovf), 32'd0);
        drive(1'b0, 1'b1, 32'h8, 32'h8, 1'b0, 1'b0);
        tick();
        chk("drop count", 32'(count), 32'd8);
        chk("drop ovf", 32'(ovf), 32'd1);
        chk("drop cnt", 32'(drop_cnt), 32'd1);
        drive(1'b0, 1'b1, 32'h100, 32'h77, 1'b0, 1'b0);
        tick();
        chk("mismatch full drop", 32'(drop_cnt), 32'd1);
        chk("mismatch full count", 32'(count), 32'd8);
        drive(1'b0, 1'b1, 32'h9, 32'h9, 1'b0, 1'b1);
        tick();
        chk("clr+drop cnt", 32'(drop_cnt), 32'd1);
        chk("clr+drop ovf", 32'(ovf), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        chk("clr cnt", 32'(drop_cnt), 32'd0);
        chk("clr ovf", 32'(ovf), 32'd0);
        idle();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d data", i), out_data, 32'(i));
            chk($sformatf("drain%0d addr", i), out_addr, 32'(i));
            out_ready = 1'b1;
            tick();
        end
        chk("drained count", 32'(count), 32'd0);
        chk("drained valid", 32'(out_valid), 32'd0);

        // Full FIFO with a simultaneous pop and write: stored, not dropped
        do_reset();
        fill8();
        drive(1'b0, 1'b1, 32'h55, 32'h55, 1'b1, 1'b0);
        tick();
        chk("fullpop count", 32'(count), 32'd8);
        chk("fullpop drop", 32'(drop_cnt), 32'd0);
        chk("fullpop ovf", 32'(ovf), 32'd0);
        idle();
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("fp drain%0d", i), out_data, (i == 8) ? 32'h55 : 32'(i));
            out_ready = 1'b1;
            tick();
        end
        chk("fp empty", 32'(out_valid), 32'd0);

        // Streaming across pointer wrap with three entries resident
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h4, 32'(100 + i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 32'h4, 32'(103 + i), 1'b1, 1'b0);
            tick();
            chk($sformatf("stream%0d count", i), 32'(count), 32'd3);
            chk($sformatf("stream%0d head", i), out_data, 32'(101 + i));
        end

        // Reset mid-stream wins over a concurrent write
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'h8, 32'(200 + i), 1'b0, 1'b0);
            tick();
        end
        chk("pre-rst count", 32'(count), 32'd5);
        drive(1'b1, 1'b1, 32'h8, 32'hABCD, 1'b1, 1'b0);
        tick();
        chk("rst count", 32'(count), 32'd0);
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst addr", out_addr, 32'h0);
        chk("rst data", out_data, 32'h0);
        idle();
        tick();
        chk("post-rst valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
